// File: rtl/reg_bank_pkg.sv
// Shared constants and decode helper for the mini MIPS register bank.
// The read-side 8:1 selector uses the same constants.
package reg_bank_pkg;

    localparam int NUM_REGS       = 8;
    localparam int ADDR_W         = 3;
    localparam int DATA_W_DEFAULT = 32;

    // One-hot decode of a register index; bit i set selects register i.
    function automatic logic [NUM_REGS-1:0] onehot8(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/reg_write_demux_req_fifo.sv
// Generic in-order request queue: DEPTH entries of W bits.
// Pointers wrap modulo DEPTH. Occupancy is tracked in a separate counter.
// Push is ignored while full and pop is ignored while empty.
module req_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Storage: written only on an accepted push, so idle-cycle inputs never land here.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/reg_write_demux.sv
// 1-to-8 write demultiplexer for the mini MIPS register bank.
// Requests queue in order and drain one per cycle into eight holding
// registers, with a registered one-hot strobe marking each write.
module reg_write_demux
    import reg_bank_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 2,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           stall,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic [NUM_REGS*DATA_W-1:0]     q_flat,
    output logic [$clog2(DEPTH+1)-1:0]     pending
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   head;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_data;
    logic [NUM_REGS-1:0]  strobe_reg;
    logic [DATA_W-1:0]    regs_reg [NUM_REGS];

    // Ready depends only on registered occupancy: no same-cycle pass-through.
    assign wr_ready  = !fifo_full;
    assign push      = wr_valid && wr_ready;
    assign pop       = !stall && !fifo_empty;
    assign head_addr = head[ENTRY_W-1 -: ADDR_W];
    assign head_data = head[DATA_W-1:0];
    assign wr_strobe = strobe_reg;

    req_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({wr_addr, wr_data}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // Strobe pulses for the register written on this edge; idle or stalled cycles give zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_reg <= '0;
        end else begin
            strobe_reg <= pop ? onehot8(head_addr) : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (ZERO_REG0 && gi == 0) begin : g_zero
                // $zero: writes are drained (strobe still fires) but data is dropped.
                assign regs_reg[gi] = '0;
            end else begin : g_live
                // Holding register loads when the head entry targets it.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        regs_reg[gi] <= '0;
                    end else if (pop && head_addr == ADDR_W'(gi)) begin
                        regs_reg[gi] <= head_data;
                    end
                end
            end
            assign q_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_reg_write_demux.sv
// Scoreboard bench for reg_write_demux. Two instances share stimulus:
// dut_a has register 0 hard-wired to zero, dut_b treats it as ordinary.
module tb_reg_write_demux;
    import reg_bank_pkg::*;

    localparam int DW = 32;

    typedef struct {
        logic [2:0]    addr;
        logic [DW-1:0] data;
    } req_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            stall = 1'b0;
    logic [2:0]      wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            ready_a, ready_b;
    logic [7:0]      strobe_a, strobe_b;
    logic [8*DW-1:0] q_a, q_b;
    logic [1:0]      pend_a, pend_b;

    req_t          exp_q[$];
    logic [DW-1:0] model_a [8];
    logic [DW-1:0] model_b [8];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    reg_write_demux #(.DATA_W(DW), .DEPTH(2), .ZERO_REG0(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_a),
        .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
        .wr_strobe(strobe_a), .q_flat(q_a), .pending(pend_a)
    );

    reg_write_demux #(.DATA_W(DW), .DEPTH(2), .ZERO_REG0(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
        .wr_strobe(strobe_b), .q_flat(q_b), .pending(pend_b)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [8*DW-1:0] flat(input logic [DW-1:0] m [8]);
        logic [8*DW-1:0] f;
        for (int i = 0; i < 8; i++) f[i*DW +: DW] = m[i];
        return f;
    endfunction

    task automatic clear_models();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for the next edge; the expectation enters the scoreboard only if it should be accepted.
    task automatic drive(input logic [2:0] a, input logic [DW-1:0] d, input bit accept);
        req_t r;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        if (accept) begin
            r.addr = a;
            r.data = d;
            exp_q.push_back(r);
        end
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_addr  = 3'bxxx;
        wr_data  = 'x;
    endtask

    // Monitor: each strobe pops the oldest expected write; register contents are checked every cycle.
    always @(negedge clk) begin
        req_t e;
        if (strobe_a !== 8'h00 || strobe_b !== 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {248'd0, strobe_a}, 256'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_a", {248'd0, strobe_a}, {248'd0, onehot8(e.addr)});
                chk("strobe_b", {248'd0, strobe_b}, {248'd0, onehot8(e.addr)});
                if (e.addr != 3'd0) model_a[e.addr] = e.data;
                model_b[e.addr] = e.data;
                $display("write addr=%0d data=%08h strobe=%02h", e.addr, e.data, strobe_a);
            end
        end
        chk("q_flat_a", q_a, flat(model_a));
        chk("q_flat_b", q_b, flat(model_b));
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_models();
        idle();
        repeat (3) cyc();
        rst_n = 1'b1;

        // 1. reset then idle
        for (int i = 0; i < 6; i++) begin
            chk("idle_q", q_a, '0);
            chk("idle_strobe", {248'd0, strobe_a}, 256'd0);
            chk("idle_pending", {254'd0, pend_a}, 256'd0);
            chk("idle_ready", {255'd0, ready_a}, 256'd1);
            cyc();
        end

        // 2. single write to reg5
        drive(3'd5, 32'hDEADBEEF, 1'b1);
        cyc();
        idle();
        chk("w5_pending", {254'd0, pend_a}, 256'd1);
        chk("w5_strobe_early", {248'd0, strobe_a}, 256'd0);
        cyc();
        chk("w5_strobe", {248'd0, strobe_a}, 256'h20);
        chk("w5_reg5", {224'd0, q_a[5*DW +: DW]}, {224'd0, 32'hDEADBEEF});
        cyc();
        chk("w5_strobe_once", {248'd0, strobe_a}, 256'd0);

        // 3. register 0: zero-wired in dut_a, ordinary in dut_b
        drive(3'd0, 32'h1234, 1'b1);
        cyc();
        idle();
        cyc();
        chk("r0_strobe", {248'd0, strobe_a}, 256'h01);
        chk("r0_zero_a", {224'd0, q_a[DW-1:0]}, 256'd0);
        chk("r0_live_b", {224'd0, q_b[DW-1:0]}, 256'h1234);
        cyc();

        // 4. stall fill and backpressure
        stall = 1'b1;
        drive(3'd1, 32'h11, 1'b1);
        cyc();
        drive(3'd2, 32'h22, 1'b1);
        cyc();
        chk("bp_pending", {254'd0, pend_a}, 256'd2);
        chk("bp_ready", {255'd0, ready_a}, 256'd0);
        drive(3'd7, 32'h77, 1'b0);
        cyc();
        idle();
        chk("bp_reject_pending", {254'd0, pend_a}, 256'd2);
        chk("bp_stall_strobe", {248'd0, strobe_a}, 256'd0);
        stall = 1'b0;
        cyc();
        chk("bp_reg1", {224'd0, q_a[1*DW +: DW]}, 256'h11);
        chk("bp_strobe1", {248'd0, strobe_a}, 256'h02);
        chk("bp_ready_back", {255'd0, ready_a}, 256'd1);
        cyc();
        chk("bp_reg2", {224'd0, q_a[2*DW +: DW]}, 256'h22);
        chk("bp_strobe2", {248'd0, strobe_a}, 256'h04);
        chk("bp_empty", {254'd0, pend_a}, 256'd0);
        cyc();

        // 5. same-address stream with simultaneous push and pop
        drive(3'd3, 32'hA, 1'b1);
        cyc();
        chk("ord_pending_a", {254'd0, pend_a}, 256'd1);
        drive(3'd3, 32'hB, 1'b1);
        cyc();
        chk("ord_pending_b", {254'd0, pend_a}, 256'd1);
        chk("ord_reg3_a", {224'd0, q_a[3*DW +: DW]}, 256'hA);
        drive(3'd3, 32'hC, 1'b1);
        cyc();
        chk("ord_pending_c", {254'd0, pend_a}, 256'd1);
        chk("ord_reg3_b", {224'd0, q_a[3*DW +: DW]}, 256'hB);
        idle();
        cyc();
        chk("ord_drained", {254'd0, pend_a}, 256'd0);
        chk("ord_reg3_c", {224'd0, q_a[3*DW +: DW]}, 256'hC);
        cyc();

        // 6. reset mid-operation discards queued entries
        stall = 1'b1;
        drive(3'd4, 32'h44, 1'b0);
        cyc();
        drive(3'd6, 32'h66, 1'b0);
        cyc();
        idle();
        chk("rst_pending_before", {254'd0, pend_a}, 256'd2);
        #2;
        rst_n = 1'b0;
        clear_models();
        #1;
        chk("rst_q", q_a, '0);
        chk("rst_strobe", {248'd0, strobe_a}, 256'd0);
        chk("rst_pending", {254'd0, pend_a}, 256'd0);
        chk("rst_ready", {255'd0, ready_a}, 256'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (5) cyc();
        chk("rst_after_pending", {254'd0, pend_a}, 256'd0);
        chk("sb_empty", exp_q.size(), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_write_demux.md
Name: reg_write_demux

Overview:
1-to-8 write-side demultiplexer for the mini MIPS register bank; it is the write counterpart of the 8:1 read selector. It accepts write requests of data plus a 3-bit destination through a valid/ready handshake and buffers them in a small in-order queue. It drains one request per cycle into one of eight holding registers and emits a registered one-hot write strobe. A stall input freezes draining during pipeline holds.

Parameters:
DATA_W, 32, width of each register and of write data
DEPTH, 2, request queue depth (>=1)
ZERO_REG0, 1, when 1 register 0 is hard-wired to zero (MIPS $zero semantics)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request present
wr_ready  output  1  queue can accept a request this cycle
wr_addr  input  3  destination register index 0..7 (addr[2] is MSB; value i selects register i)
wr_data  input  DATA_W  write data
stall  input  1  when 1, no request is drained this cycle
wr_strobe  output  8  registered one-hot: bit i pulses for one cycle when register i is written
q_flat  output  8*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W]
pending  output  clog2(DEPTH+1)  current queue occupancy

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asynchronous): all 8 registers = 0, wr_strobe = 0, queue emptied, pending = 0, wr_ready = 1. Queued requests are discarded when reset asserts mid-operation. Normal operation resumes on the first clk edge after rst_n deasserts.
- Accept: a request is pushed at a rising edge when wr_valid && wr_ready.
- wr_ready = (pending < DEPTH). It depends only on registered occupancy, with no same-cycle pass-through. When full, wr_ready = 0 even if a pop occurs that cycle.
- Drain: at a rising edge, if pending > 0 && !stall, the oldest entry pops.
  - The target register gets its data on that edge.
  - On the same edge wr_strobe gets the one-hot of its addr. Otherwise wr_strobe = 0.
- Latency: a request accepted at edge N into an empty queue with stall=0 is visible in q_flat and wr_strobe after edge N+1. With no bypass, the minimum latency is 1 cycle.
- Ordering: strict FIFO. Back-to-back writes to the same address resolve last-writer-wins, in order.
- Simultaneous push and pop: pending is unchanged. The pushed entry goes behind any remaining entries.
- Register 0 with ZERO_REG0=1: data is discarded and the register stays 0, but wr_strobe[0] still pulses, so the bench sees the drain. With ZERO_REG0=0, register 0 is an ordinary register.
- Stall: holds queue contents and all registers, and forces wr_strobe = 0. Pushes are still accepted while not full.
- Queue pointers wrap modulo DEPTH. Occupancy saturates at DEPTH by construction, because no push happens while full.
- wr_addr and wr_data are sampled only on an accepted push. Values on cycles with wr_valid=0 are ignored. X on wr_addr with wr_valid=0 must not propagate.

Decomposition:
- Shared package reg_bank_pkg: NUM_REGS=8, ADDR_W=3, default DATA_W, and a function onehot8(addr) returning the 8-bit decode. The same constants are used by the read-side selector.
- One sub-module, req_fifo: a generic DEPTH x (ADDR_W+DATA_W) synchronous FIFO with push/pop/full/empty/count and async active-low reset.
- Top level holds the decode, the register array and the strobe register.

Test Plan:
1. Reset then idle: after rst_n rises, check q_flat=0, wr_strobe=0, pending=0, wr_ready=1; hold 5 cycles and check nothing changes.
2. Single write: push addr=5, data=0xDEADBEEF at edge N with stall=0. After N+1 check reg5=0xDEADBEEF, wr_strobe=8'b0010_0000 for exactly one cycle, all other registers 0.
3. Zero register: with ZERO_REG0=1, push addr=0, data=0x1234. Check wr_strobe=8'b0000_0001 pulses and reg0 stays 0. Repeat with ZERO_REG0=0 and check reg0=0x1234.
4. Stall fill/backpressure: stall=1, push addr=1/0x11 then addr=2/0x22. Check pending=2, wr_ready=0, and that a third request with wr_valid=1 is not accepted. Release stall: reg1=0x11 on the next edge, reg2=0x22 the edge after, strobes 0x02 then 0x04, wr_ready returns to 1 once pending < 2.
5. Same-address ordering plus simultaneous push/pop: stream addr=3 with 0xA, 0xB, 0xC on consecutive cycles with stall=0. Check pending stays at 1 and reg3 ends at 0xC after the sequence 0xA, 0xB, 0xC.
6. Reset mid-operation: with 2 entries queued under stall, assert rst_n=0 asynchronously between edges. Check outputs clear immediately, and after release with stall=0 no strobe ever fires for the discarded entries.
